// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares the single SDRAM port between four requesters:
//   0 = CD/DMA write, 1 = C ROM burst, 2 = S ROM, 3 = 68k/DMA read.
//   Request strobes are latched into PENDING. When the port is idle and the
//   controller is ready, one winner is chosen: lowest index first, unless
//   requester 3 has been waiting STARVE_MAX cycles or more. The winner gets a
//   one-cycle RD/WR start pulse and holds GRANT until the controller's ready
//   flag rises again, at which point DONE pulses for one cycle. A WAIT that
//   outlasts TIMEOUT cycles releases the port without DONE and sets the sticky
//   TIMEOUT_ERR flag.
//
// Ports
//   clk_sys          system clock, rising edge
//   nRESET           asynchronous active-low reset
//   REQ_STB[3:0]     single-cycle request strobes
//   REQ_EN[3:0]      per-requester enables; disabled pending requests are dropped
//   sdram_ready      controller idle flag
//   SDRAM_RD_PULSE   one-cycle read start
//   SDRAM_WR_PULSE   one-cycle write start
//   SDRAM_RD_TYPE    0 single, 1 burst (valid while GRANT is nonzero)
//   GRANT[3:0]       one-hot port owner, 0 when idle
//   DONE[3:0]        one-cycle completion pulse to the owner
//   PENDING[3:0]     latched, not yet granted requests
//   BUSY             GRANT != 0
//   TIMEOUT_ERR      sticky WAIT timeout flag
module sdram_arbiter #(
  parameter logic [3:0]  WR_MASK    = 4'b0001,
  parameter logic [3:0]  BURST_MASK = 4'b0010,
  parameter int unsigned STARVE_MAX = 64,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic       clk_sys,
  input  logic       nRESET,
  input  logic [3:0] REQ_STB,
  input  logic [3:0] REQ_EN,
  input  logic       sdram_ready,
  output logic       SDRAM_RD_PULSE,
  output logic       SDRAM_WR_PULSE,
  output logic       SDRAM_RD_TYPE,
  output logic [3:0] GRANT,
  output logic [3:0] DONE,
  output logic [3:0] PENDING,
  output logic       BUSY,
  output logic       TIMEOUT_ERR
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] done_q, done_d;
  logic       rd_pulse_q, rd_pulse_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic       rd_type_q, rd_type_d;
  logic       terr_q, terr_d;
  logic       ready_q;
  logic [7:0] starve_q, starve_d;
  logic [7:0] tmo_q, tmo_d;

  logic [3:0] eligible;
  logic [3:0] win_oh;
  logic       arb_fire;
  logic       win_is_wr;

  always_comb begin
    eligible = pending_q & REQ_EN;
    // Starved 68k overrides priority; otherwise isolate the lowest set bit.
    if (eligible[3] && (starve_q >= STARVE_LIM)) begin
      win_oh = 4'b1000;
    end else begin
      win_oh = eligible & (~eligible + 4'd1);
    end
    arb_fire  = (state_q == ST_IDLE) && sdram_ready && (|eligible);
    win_is_wr = |(win_oh & WR_MASK);
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    grant_d    = grant_q;
    done_d     = '0;
    rd_pulse_d = 1'b0;
    wr_pulse_d = 1'b0;
    rd_type_d  = rd_type_q;
    terr_d     = terr_q;
    tmo_d      = tmo_q;
    starve_d   = starve_q;

    case (state_q)
      ST_IDLE: begin
        if (sdram_ready) begin
          pending_d = pending_q & REQ_EN;
          if (|eligible) begin
            grant_d    = win_oh;
            pending_d  = pending_d & ~win_oh;
            wr_pulse_d = win_is_wr;
            rd_pulse_d = ~win_is_wr;
            rd_type_d  = |(win_oh & BURST_MASK);
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!ready_q && sdram_ready) begin
          done_d    = grant_q;
          grant_d   = '0;
          rd_type_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          grant_d   = '0;
          rd_type_d = 1'b0;
          terr_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // New strobes are merged after grant/drop so a strobe for the bit being
    // granted starts a fresh request instead of being lost.
    pending_d = pending_d | REQ_STB;

    if (!pending_q[3] || (arb_fire && win_oh[3])) begin
      starve_d = '0;
    end else if (REQ_EN[3] && !grant_q[3] && (starve_q != 8'hFF)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      rd_pulse_q <= 1'b0;
      wr_pulse_q <= 1'b0;
      rd_type_q  <= 1'b0;
      terr_q     <= 1'b0;
      ready_q    <= 1'b0;
      starve_q   <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      rd_pulse_q <= rd_pulse_d;
      wr_pulse_q <= wr_pulse_d;
      rd_type_q  <= rd_type_d;
      terr_q     <= terr_d;
      ready_q    <= sdram_ready;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
    end
  end

  assign SDRAM_RD_PULSE = rd_pulse_q;
  assign SDRAM_WR_PULSE = wr_pulse_q;
  assign SDRAM_RD_TYPE  = rd_type_q;
  assign GRANT          = grant_q;
  assign DONE           = done_q;
  assign PENDING        = pending_q;
  assign BUSY           = |grant_q;
  assign TIMEOUT_ERR    = terr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Random requests, enables and SDRAM ready timing drive sdram_arbiter; a
//   transaction-level reference model predicts every output each cycle.
module tb_sdram_arbiter;

  localparam logic [3:0] WR_M    = 4'b0001;
  localparam logic [3:0] BURST_M = 4'b0010;
  localparam int         SM      = 4;
  localparam int         TO      = 8;
  localparam int         NCYC    = 3000;

  logic       clk_sys;
  logic       nRESET;
  logic [3:0] REQ_STB;
  logic [3:0] REQ_EN;
  logic       sdram_ready;
  logic       SDRAM_RD_PULSE;
  logic       SDRAM_WR_PULSE;
  logic       SDRAM_RD_TYPE;
  logic [3:0] GRANT;
  logic [3:0] DONE;
  logic [3:0] PENDING;
  logic       BUSY;
  logic       TIMEOUT_ERR;

  sdram_arbiter #(
    .WR_MASK   (WR_M),
    .BURST_MASK(BURST_M),
    .STARVE_MAX(SM),
    .TIMEOUT   (TO)
  ) dut (
    .clk_sys       (clk_sys),
    .nRESET        (nRESET),
    .REQ_STB       (REQ_STB),
    .REQ_EN        (REQ_EN),
    .sdram_ready   (sdram_ready),
    .SDRAM_RD_PULSE(SDRAM_RD_PULSE),
    .SDRAM_WR_PULSE(SDRAM_WR_PULSE),
    .SDRAM_RD_TYPE (SDRAM_RD_TYPE),
    .GRANT         (GRANT),
    .DONE          (DONE),
    .PENDING       (PENDING),
    .BUSY          (BUSY),
    .TIMEOUT_ERR   (TIMEOUT_ERR)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port, whether this is the start-pulse
  // cycle, how long it has waited, and what is queued.
  logic [3:0] m_pend;
  int         m_owner;
  bit         m_issue;
  int         m_wait;
  int         m_starve;
  bit         m_prev_rdy;
  int         m_done;
  bit         m_terr;

  task automatic model_reset();
    m_pend     = '0;
    m_owner    = -1;
    m_issue    = 1'b0;
    m_wait     = 0;
    m_starve   = 0;
    m_prev_rdy = 1'b0;
    m_done     = -1;
    m_terr     = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] stb, input logic [3:0] en, input bit rdy);
    logic [3:0] old_pend;
    logic [3:0] elig;
    int         old_owner;
    bit         got3;
    int         w;
    old_pend  = m_pend;
    old_owner = m_owner;
    got3      = 1'b0;
    m_done    = -1;
    if (m_owner < 0) begin
      if (rdy) begin
        elig   = old_pend & en;
        m_pend = m_pend & en;
        if (elig != 4'b0) begin
          if (m_starve >= SM && elig[3]) begin
            w = 3;
          end else begin
            w = 0;
            while (!elig[w]) w++;
          end
          m_owner   = w;
          m_issue   = 1'b1;
          m_pend[w] = 1'b0;
          got3      = (w == 3);
        end
      end
    end else if (m_issue) begin
      m_issue = 1'b0;
      m_wait  = 0;
    end else if (!m_prev_rdy && rdy) begin
      m_done  = m_owner;
      m_owner = -1;
    end else if (m_wait + 1 >= TO) begin
      m_owner = -1;
      m_terr  = 1'b1;
    end else begin
      m_wait++;
    end
    m_pend = m_pend | stb;
    if (got3 || !old_pend[3]) m_starve = 0;
    else if (en[3] && old_owner != 3 && m_starve < 255) m_starve++;
    m_prev_rdy = rdy;
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    logic [3:0] ed;
    bit         is_wr;
    eg = '0;
    ed = '0;
    is_wr = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      is_wr = WR_M[m_owner];
    end
    if (m_done >= 0) ed[m_done] = 1'b1;
    check("grant",   32'(GRANT),          32'(eg));
    check("done",    32'(DONE),           32'(ed));
    check("pending", 32'(PENDING),        32'(m_pend));
    check("busy",    32'(BUSY),           32'(m_owner >= 0));
    check("rd_pls",  32'(SDRAM_RD_PULSE), 32'(m_issue && !is_wr));
    check("wr_pls",  32'(SDRAM_WR_PULSE), 32'(m_issue && is_wr));
    check("tmo_err", 32'(TIMEOUT_ERR),    32'(m_terr));
    if (m_owner >= 0) check("rd_type", 32'(SDRAM_RD_TYPE), 32'(BURST_M[m_owner]));
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_grant"},   32'(GRANT),          32'h0);
    check({pfx, "_done"},    32'(DONE),           32'h0);
    check({pfx, "_pending"}, 32'(PENDING),        32'h0);
    check({pfx, "_busy"},    32'(BUSY),           32'h0);
    check({pfx, "_rd"},      32'(SDRAM_RD_PULSE), 32'h0);
    check({pfx, "_wr"},      32'(SDRAM_WR_PULSE), 32'h0);
    check({pfx, "_rdtype"},  32'(SDRAM_RD_TYPE),  32'h0);
    check({pfx, "_tmo"},     32'(TIMEOUT_ERR),    32'h0);
  endtask

  initial begin
    int lo_cnt;
    int rst_next;
    lo_cnt      = 0;
    rst_next    = 500;
    nRESET      = 1'b0;
    REQ_STB     = '0;
    REQ_EN      = 4'hF;
    sdram_ready = 1'b1;
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clk_sys);
    @(posedge clk_sys);
    #2 nRESET = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk_sys);
      #1;
      model_step(REQ_STB, REQ_EN, sdram_ready);
      compare_all();

      // Asynchronous reset landing in the middle of a WAIT.
      if (cyc >= rst_next && m_owner >= 0 && !m_issue) begin
        #2 nRESET = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        lo_cnt      = 0;
        REQ_STB     = '0;
        sdram_ready = 1'b1;
        @(posedge clk_sys);
        #2 nRESET = 1'b1;
        rst_next = cyc + 600;
      end

      // Controller: ready drops after a start pulse, rises a few cycles
      // later, or occasionally stays low past the timeout.
      if (m_issue) lo_cnt = ($urandom_range(0, 7) == 0) ? TO + 4 : int'($urandom_range(1, 6));
      if (lo_cnt > 0) begin
        sdram_ready = 1'b0;
        lo_cnt--;
      end else begin
        sdram_ready = 1'b1;
      end

      for (int b = 0; b < 4; b++) REQ_STB[b] = ($urandom_range(0, 5) == 0);
      REQ_EN = {1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b1};
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
